// File: rtl/reg_readout_tx_pkg.sv
// Shared types and constants for the register read-back serial transmitter.
package reg_readout_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArmed  = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StParity = 3'd4,
    StStop   = 3'd5
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // A counter must be at least one bit wide, even for a single-bit data field.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/reg_readout_tx_if.sv
// Request/tick inputs and serial/status outputs of the read-back transmitter.
interface reg_readout_tx_if #(
  parameter int unsigned REGISTER_WIDTH = 4,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned SEL_WIDTH      = 2
);
  logic [NUM_REGS*REGISTER_WIDTH-1:0] regs_i;
  logic [SEL_WIDTH-1:0]               sel_i;
  logic                               req_i;
  logic                               tick_i;
  logic                               ser_o;
  logic                               busy_o;
  logic                               done_o;
  logic [REGISTER_WIDTH-1:0]          data_o;

  modport master (
    output regs_i, sel_i, req_i, tick_i,
    input  ser_o, busy_o, done_o, data_o
  );

  modport slave (
    input  regs_i, sel_i, req_i, tick_i,
    output ser_o, busy_o, done_o, data_o
  );
endinterface

// File: rtl/reg_readout_tx.sv
// Captures one selected register on request and shifts it out as
// start / data LSB-first / optional even parity / stop, one bit per tick.
module reg_readout_tx
  import reg_readout_tx_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 4,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned PARITY_EN      = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  reg_readout_tx_if.slave   tx_bus
);

  localparam int unsigned CntW = cnt_width(REGISTER_WIDTH);

  state_e                    r_state, w_state_d;
  logic [REGISTER_WIDTH-1:0] r_shift, w_shift_d;
  logic [REGISTER_WIDTH-1:0] r_data, w_data_d;
  logic [REGISTER_WIDTH-1:0] w_sel_val;
  logic [CntW-1:0]           r_cnt, w_cnt_d;
  logic                      r_par, w_par_d;
  logic                      r_ser, w_ser_d;
  logic                      w_done;

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_sel_val = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (tx_bus.sel_i == SEL_WIDTH'(k)) begin
        w_sel_val = tx_bus.regs_i[k*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_data_d  = r_data;
    w_cnt_d   = r_cnt;
    w_par_d   = r_par;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (tx_bus.req_i) begin
          w_state_d = StArmed;
          w_shift_d = w_sel_val;
          w_data_d  = w_sel_val;
          w_par_d   = ^w_sel_val;
          w_cnt_d   = '0;
        end
      end
      StArmed: if (tx_bus.tick_i) w_state_d = StStart;
      StStart: begin
        if (tx_bus.tick_i) begin
          w_state_d = StData;
          w_cnt_d   = '0;
        end
      end
      StData: begin
        if (tx_bus.tick_i) begin
          if (r_cnt == CntW'(REGISTER_WIDTH - 1)) begin
            w_state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            w_shift_d = r_shift >> 1;
            w_cnt_d   = r_cnt + CntW'(1);
          end
        end
      end
      StParity: if (tx_bus.tick_i) w_state_d = StStop;
      StStop: begin
        if (tx_bus.tick_i) begin
          w_state_d = StIdle;
          w_done    = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so ser_o comes straight from a flop.
  always_comb begin
    w_ser_d = LINE_IDLE;
    unique case (w_state_d)
      StStart:  w_ser_d = START_BIT;
      StData:   w_ser_d = w_shift_d[0];
      StParity: w_ser_d = r_par;
      default:  w_ser_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_ser   <= LINE_IDLE;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_cnt   <= w_cnt_d;
      r_par   <= w_par_d;
      r_ser   <= w_ser_d;
    end
  end

  assign tx_bus.ser_o  = r_ser;
  assign tx_bus.busy_o = (r_state != StIdle);
  assign tx_bus.done_o = w_done;
  assign tx_bus.data_o = r_data;

endmodule
